// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the word-to-byte memory bridge.
package mem_bridge_pkg;

    // Bytes per word, which is also the number of byte beats per transfer.
    localparam int BEATS = 4;

    // One byte lane of a word.
    typedef logic [7:0] byte_t;

    // Bridge FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_LAST = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

endpackage

// File: rtl/mem_bridge.sv
// Bridges single-word core requests onto a byte-wide memory port.
// Each transfer is four byte beats. The read data returns one cycle late,
// so reads need an extra RD_LAST cycle to collect the final byte.
module mem_bridge #(
    parameter int ADDR_W = 32,
    parameter int BEATS  = mem_bridge_pkg::BEATS
) (
    input  logic                                  clk,
    input  logic                                  rst_b,
    input  logic                                  halted,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [ADDR_W-1:0]                     req_addr,
    input  logic                                  req_we,
    input  mem_bridge_pkg::byte_t [BEATS-1:0]     req_wdata,
    output logic                                  resp_valid,
    input  logic                                  resp_ready,
    output mem_bridge_pkg::byte_t [BEATS-1:0]     resp_rdata,
    output logic                                  mem_en,
    output logic                                  mem_we,
    output logic [ADDR_W-1:0]                     mem_addr,
    output logic [7:0]                            mem_wdata,
    input  logic [7:0]                            mem_rdata
);

    import mem_bridge_pkg::*;

    state_e                state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    byte_t [BEATS-1:0]     wdata_q, wdata_d;
    byte_t [BEATS-1:0]     rdata_q, rdata_d;

    // State registers; reset abandons any transfer in flight without a response.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            beat_q  <= 2'd0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: request acceptance, beat sequencing, read-byte capture.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && !halted) begin
                    base_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = req_wdata;
                    beat_d  = 2'd0;
                    state_d = req_we ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = ST_RESP;
                end
            end
            ST_RD: begin
                // The byte arriving now belongs to the previous beat's address.
                if (beat_q != 2'd0) begin
                    rdata_d[beat_q - 2'd1] = mem_rdata;
                end
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = ST_RD_LAST;
                end
            end
            ST_RD_LAST: begin
                rdata_d[3] = mem_rdata;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so reset removes the strobes at once.
    always_comb begin
        req_ready  = (state_q == ST_IDLE) && !halted;
        resp_valid = (state_q == ST_RESP);
        resp_rdata = rdata_q;
        mem_en     = (state_q == ST_WR) || (state_q == ST_RD);
        mem_we     = (state_q == ST_WR);
        mem_addr   = base_q;
        mem_wdata  = 8'h00;
        if (mem_en) begin
            // Beat replaces the low two bits, so the address never carries out of the word.
            mem_addr = {base_q[ADDR_W-1:2], beat_q};
        end
        if (state_q == ST_WR) begin
            mem_wdata = wdata_q[beat_q];
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge with a byte-memory model behind the bridge.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        halted;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;

    mem_bridge dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .halted     (halted),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Byte memory: low 12 address bits, preset to addr^0x5A, read data one cycle late.
    logic [7:0] mem [0:4095];
    bit         mem_init_done = 1'b0;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (!mem_init_done) begin
            for (int i = 0; i < 4096; i++) begin
                mem[i] <= 8'(i) ^ 8'h5A;
            end
            mem_init_done <= 1'b1;
        end else begin
            if (mem_en && mem_we) begin
                mem[mem_addr[11:0]] <= mem_wdata;
            end
            if (mem_en && !mem_we) begin
                mem_rdata <= mem[mem_addr[11:0]];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          hold;
        int          halt_at;
    } vec_t;

    // One full transfer: accept, per-beat bus checks, latency, response hold and handshake.
    task automatic do_xact(input vec_t v, output logic [31:0] rd, output int lat);
        logic [31:0] base;
        logic [31:0] exp_addr;
        logic [7:0]  exp_byte;
        bit          acc;
        base = {v.addr[31:2], 2'b00};
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", 64'(acc), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = '0;
        lat = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (resp_valid) begin
                lat = cyc;
                break;
            end
            if (cyc <= 4) begin
                exp_addr = base + 32'(cyc - 1);
                exp_byte = v.we ? v.wdata[8*(cyc-1) +: 8] : 8'h00;
                check("beat_en", 64'(mem_en), 64'd1);
                check("beat_we", 64'(mem_we), 64'(v.we));
                check("beat_addr", 64'(mem_addr), 64'(exp_addr));
                check("beat_wdata", 64'(mem_wdata), 64'(exp_byte));
            end else begin
                check("rd_last_en", 64'(mem_en), 64'd0);
                check("rd_last_addr", 64'(mem_addr), 64'(base));
            end
            if (cyc == v.halt_at) begin
                halted = 1'b1;
            end
            @(negedge clk);
        end
        check("latency", 64'(lat), 64'(v.exp_lat));
        rd = resp_rdata;
        check("rdata", 64'(rd), 64'(v.exp_rdata));
        for (int h = 0; h < v.hold; h++) begin
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_rdata", 64'(resp_rdata), 64'(v.exp_rdata));
            check("hold_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("post_hs_valid", 64'(resp_valid), 64'd0);
        check("post_hs_req_ready", 64'(req_ready), 64'(!halted));
        $display("XACT we=%0d addr=%08h wdata=%08h rdata=%08h lat=%0d hold=%0d",
                 v.we, v.addr, v.wdata, rd, lat, v.hold);
    endtask

    vec_t        vecs [8];
    logic [31:0] rd;
    int          lat;
    int          acc_t [2];
    int          n_acc;
    bit          seen;

    initial begin
        rst_b      = 1'b0;
        halted     = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        rst_b = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);

        //         we    addr           wdata          exp_rdata      lat hold halt
        vecs[0] = '{1'b1, 32'h0000_0102, 32'h4433_2211, 32'h0000_0000, 5, 0, 0};
        vecs[1] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 32'h4433_2211, 6, 0, 0};
        vecs[2] = '{1'b1, 32'h0000_0203, 32'hDDCC_BBAA, 32'h4433_2211, 5, 3, 0};
        vecs[3] = '{1'b0, 32'h0000_0201, 32'h0000_0000, 32'hDDCC_BBAA, 6, 3, 0};
        vecs[4] = '{1'b0, 32'h0000_0300, 32'h0000_0000, 32'h5958_5B5A, 6, 0, 0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFE, 32'h0102_0304, 32'h5958_5B5A, 5, 0, 0};
        vecs[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0102_0304, 6, 0, 0};
        vecs[7] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 32'h4433_2211, 6, 0, 3};

        for (int k = 0; k < 8; k++) begin
            do_xact(vecs[k], rd, lat);
            halted = 1'b0;
        end

        // Halted in idle: request must be ignored
        @(negedge clk);
        halted    = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("halted_req_ready", 64'(req_ready), 64'd0);
            check("halted_mem_en", 64'(mem_en), 64'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        halted    = 1'b0;
        $display("XACT halted-idle request ignored for 4 cycles");

        // Reset during write beat 2: first two bytes land, the rest do not
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0100;
        req_wdata = 32'h9988_7766;
        #1;
        check("rstw_accept", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        check("rstw_beat2_addr", 64'(mem_addr), 64'h102);
        check("rstw_beat2_we", 64'(mem_we), 64'd1);
        #2;
        rst_b = 1'b0;
        #1;
        check("rstw_async_we", 64'(mem_we), 64'd0);
        check("rstw_async_en", 64'(mem_en), 64'd0);
        check("rstw_rdata_clr", 64'(resp_rdata), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("rstw_no_resp", 64'(seen), 64'd0);
        check("rstw_mem100", 64'(mem[12'h100]), 64'h66);
        check("rstw_mem101", 64'(mem[12'h101]), 64'h77);
        check("rstw_mem102", 64'(mem[12'h102]), 64'h33);
        check("rstw_mem103", 64'(mem[12'h103]), 64'h44);
        $display("XACT reset during write beat 2 at addr 00000100");
        do_xact('{1'b0, 32'h0000_0100, 32'h0, 32'h4433_7766, 6, 0, 0}, rd, lat);

        // Back-to-back writes with resp_ready tied high:
        // accept at 0, beats 1-4, handshake at 5, idle and next accept at 6
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h0000_0200;
        req_wdata  = 32'hA3A2_A1A0;
        n_acc = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        for (int i = 0; i < 40; i++) begin
            if (n_acc == 1) begin
                req_addr  = 32'h0000_0204;
                req_wdata = 32'hB3B2_B1B0;
            end
            if (req_ready) begin
                acc_t[n_acc] = cyc_cnt;
                n_acc++;
                if (n_acc == 2) break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        resp_ready = 1'b0;
        check("b2b_accepts", 64'(n_acc), 64'd2);
        check("b2b_gap", 64'(acc_t[1] - acc_t[0]), 64'd6);
        check("b2b_mem200", 64'(mem[12'h200]), 64'hA0);
        check("b2b_mem203", 64'(mem[12'h203]), 64'hA3);
        check("b2b_mem204", 64'(mem[12'h204]), 64'hB0);
        check("b2b_mem207", 64'(mem[12'h207]), 64'hB3);
        $display("XACT back-to-back writes 00000200/00000204 gap=%0d", acc_t[1] - acc_t[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
